// File: rtl/sample_arbiter.sv
// Two-source window arbiter: grants one shared sampling window, blanks, then captures strided samples.
// Define SAMPLE_ARB_PRIO_EN for fixed priority (source 0 wins ties); default is round-robin.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | no owner; arbitrate pending requests
// ST_BLANK  | window granted, y forced to zero for BLANK cycles
// ST_CAPTURE| strided capture of the owner's data into y
// ST_DONE   | window complete; done pulse to owner, grant held
module sample_arbiter #(
    parameter int W        = 4,
    parameter int BLANK    = 4,
    parameter int CAPTURES = 3,
    parameter int STRIDE   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [1:0]   req,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic [1:0]   grant,
    output logic         busy,
    output logic [W-1:0] y,
    output logic         y_valid,
    output logic [1:0]   done
);

    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int NW = (CAPTURES > 1) ? $clog2(CAPTURES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t         state_q, state_nxt;
    logic [1:0]     grant_q, grant_nxt;
    logic [BW-1:0]  bcnt_q, bcnt_nxt;
    logic [SW-1:0]  scnt_q, scnt_nxt;
    logic [NW-1:0]  ncnt_q, ncnt_nxt;
    logic [W-1:0]   y_q, y_nxt;
    logic           vld_q, vld_nxt;
    logic           win1;
    logic           owner_req;

`ifdef SAMPLE_ARB_PRIO_EN
    assign win1 = (req == 2'b10);
`else
    logic last_q, last_nxt;

    // On a tie the source that was not served last takes the window.
    assign win1 = (req == 2'b10) || ((req == 2'b11) && !last_q);
`endif

    assign owner_req = |(req & grant_q);

    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        bcnt_nxt  = bcnt_q;
        scnt_nxt  = scnt_q;
        ncnt_nxt  = ncnt_q;
        y_nxt     = y_q;
        vld_nxt   = 1'b0;
`ifndef SAMPLE_ARB_PRIO_EN
        last_nxt  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                bcnt_nxt = '0;
                scnt_nxt = '0;
                ncnt_nxt = '0;
                if (req != 2'b00) begin
                    grant_nxt = win1 ? 2'b10 : 2'b01;
                    y_nxt     = '0;
                    state_nxt = ST_BLANK;
`ifndef SAMPLE_ARB_PRIO_EN
                    last_nxt  = win1;
`endif
                end
            end
            ST_BLANK: begin
                if (!owner_req) begin
                    grant_nxt = 2'b00;
                    state_nxt = ST_IDLE;
                end else if (bcnt_q == BW'(BLANK - 1)) begin
                    bcnt_nxt  = '0;
                    state_nxt = ST_CAPTURE;
                end else begin
                    bcnt_nxt = bcnt_q + BW'(1);
                end
            end
            ST_CAPTURE: begin
                // A withdrawn request aborts the window even on a sample edge.
                if (!owner_req) begin
                    grant_nxt = 2'b00;
                    state_nxt = ST_IDLE;
                end else if (scnt_q == SW'(STRIDE - 1)) begin
                    scnt_nxt = '0;
                    y_nxt    = grant_q[1] ? x1 : x0;
                    vld_nxt  = 1'b1;
                    if (ncnt_q == NW'(CAPTURES - 1)) begin
                        ncnt_nxt  = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        ncnt_nxt = ncnt_q + NW'(1);
                    end
                end else begin
                    scnt_nxt = scnt_q + SW'(1);
                end
            end
            ST_DONE: begin
                grant_nxt = 2'b00;
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            bcnt_q  <= '0;
            scnt_q  <= '0;
            ncnt_q  <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
        end else if (enable) begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            bcnt_q  <= bcnt_nxt;
            scnt_q  <= scnt_nxt;
            ncnt_q  <= ncnt_nxt;
            y_q     <= y_nxt;
            vld_q   <= vld_nxt;
        end
    end

`ifndef SAMPLE_ARB_PRIO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (enable) begin
            last_q <= last_nxt;
        end
    end
`endif

    // Pulses are held in their registers while stalled and released once enable returns.
    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign y       = y_q;
    assign y_valid = vld_q & enable;
    assign done    = ((state_q == ST_DONE) && enable) ? grant_q : 2'b00;

endmodule

// File: tb/tb_sample_arbiter.sv
// Directed bench for sample_arbiter; captured samples are checked against a scoreboard queue.
module tb_sample_arbiter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] req;
    logic [3:0] x0;
    logic [3:0] x1;
    logic [1:0] grant;
    logic       busy;
    logic [3:0] y;
    logic       y_valid;
    logic [1:0] done;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];
    logic [3:0] exp_y;
    logic [1:0] exp_g;
    int n;
    int win;
    int exp_last;

    sample_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req),
        .x0(x0), .x1(x1), .grant(grant), .busy(busy),
        .y(y), .y_valid(y_valid), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and retire any sample the DUT presents.
    task automatic step();
        @(negedge clk);
        if (y_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("y_valid_spurious", {31'd0, y_valid}, 32'd0);
            end else begin
                exp_y = sb.pop_front();
                chk("y_sample", {28'd0, y}, {28'd0, exp_y});
            end
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; req = 2'b00; x0 = '0; x1 = '0;
        exp_last = 1;
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_y", {28'd0, y}, 32'd0);
        chk("rst_vld", {31'd0, y_valid}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_grant", {30'd0, grant}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_y", {28'd0, y}, 32'd0);
            chk("idle_vld", {31'd0, y_valid}, 32'd0);
            chk("idle_done", {30'd0, done}, 32'd0);
        end

        // Single requester, default timing
        x0 = 4'hA; req = 2'b01;
        repeat (3) sb.push_back(4'hA);
        step();
        chk("s0_grant", {30'd0, grant}, 32'd1);
        chk("s0_busy", {31'd0, busy}, 32'd1);
        chk("s0_y0", {28'd0, y}, 32'd0);
        exp_last = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("s0_grant_hold", {30'd0, grant}, 32'd1);
            chk("s0_vld", {31'd0, y_valid}, (k == 6 || k == 8 || k == 10) ? 32'd1 : 32'd0);
            chk("s0_done", {30'd0, done}, (k == 10) ? 32'd1 : 32'd0);
            if (k < 6) chk("s0_blank_y", {28'd0, y}, 32'd0);
        end
        req = 2'b00;
        step();
        chk("s0_grant_end", {30'd0, grant}, 32'd0);
        chk("s0_busy_end", {31'd0, busy}, 32'd0);

        // Both sources requesting continuously
        x0 = 4'h3; x1 = 4'h6; req = 2'b11;
        for (int w = 0; w < 3; w++) begin
`ifdef SAMPLE_ARB_PRIO_EN
            win = 0;
`else
            win = (exp_last == 0) ? 1 : 0;
`endif
            exp_last = win;
            exp_g = (win == 1) ? 2'b10 : 2'b01;
            repeat (3) sb.push_back((win == 1) ? 4'h6 : 4'h3);
            n = 0;
            while (grant === 2'b00 && n < 8) begin
                step();
                n++;
            end
            chk("rr_gap", n, 32'd1);
            chk("rr_grant", {30'd0, grant}, {30'd0, exp_g});
            for (int k = 1; k <= 10; k++) begin
                step();
                chk("rr_vld", {31'd0, y_valid}, (k == 6 || k == 8 || k == 10) ? 32'd1 : 32'd0);
                if (k == 10) chk("rr_done", {30'd0, done}, {30'd0, exp_g});
            end
            if (w == 2) req = 2'b00;
            step();
            chk("rr_idle_gap", {30'd0, grant}, 32'd0);
        end

        // Source 1 withdraws after its first sample
        x1 = 4'h9; req = 2'b10;
        sb.push_back(4'h9);
        step();
        chk("ab_grant", {30'd0, grant}, 32'd2);
        exp_last = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("ab_vld", {31'd0, y_valid}, (k == 6) ? 32'd1 : 32'd0);
        end
        req = 2'b00; x1 = 4'h2;
        step();
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_grant_drop", {30'd0, grant}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ab_no_vld", {31'd0, y_valid}, 32'd0);
            chk("ab_no_done", {30'd0, done}, 32'd0);
            chk("ab_y_hold", {28'd0, y}, 32'h9);
        end

        // Five-cycle stall in the middle of capture
        x0 = 4'hC; req = 2'b01;
        sb.push_back(4'hC);
        step();
        chk("st_grant", {30'd0, grant}, 32'd1);
        exp_last = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("st_vld_pre", {31'd0, y_valid}, (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) begin
                x0 = 4'hD;
                repeat (2) sb.push_back(4'hD);
            end
        end
        enable = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("st_vld_frozen", {31'd0, y_valid}, 32'd0);
            chk("st_done_frozen", {30'd0, done}, 32'd0);
            chk("st_grant_frozen", {30'd0, grant}, 32'd1);
            chk("st_y_frozen", {28'd0, y}, 32'hC);
        end
        enable = 1'b1;
        step();
        chk("st_vld_13", {31'd0, y_valid}, 32'd1);
        step();
        chk("st_vld_14", {31'd0, y_valid}, 32'd0);
        step();
        chk("st_vld_15", {31'd0, y_valid}, 32'd1);
        chk("st_done_15", {30'd0, done}, 32'd1);
        req = 2'b00;
        step();
        chk("st_grant_end", {30'd0, grant}, 32'd0);

        // Async reset in BLANK, then in DONE
        req = 2'b11;
        step();
`ifdef SAMPLE_ARB_PRIO_EN
        chk("rb_grant", {30'd0, grant}, 32'd1);
`else
        chk("rb_grant", {30'd0, grant}, 32'd2);
`endif
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("rb_grant_clr", {30'd0, grant}, 32'd0);
        chk("rb_busy_clr", {31'd0, busy}, 32'd0);
        chk("rb_y_clr", {28'd0, y}, 32'd0);
        chk("rb_vld_clr", {31'd0, y_valid}, 32'd0);
        chk("rb_done_clr", {30'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1; x0 = 4'h7;
        repeat (3) sb.push_back(4'h7);
        step();
        chk("rb_tie_src0", {30'd0, grant}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) chk("rd_done", {30'd0, done}, 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        chk("rd_done_clr", {30'd0, done}, 32'd0);
        chk("rd_grant_clr", {30'd0, grant}, 32'd0);
        chk("rd_busy_clr", {31'd0, busy}, 32'd0);
        chk("rd_y_clr", {28'd0, y}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rd_tie_src0", {30'd0, grant}, 32'd1);
        req = 2'b00;
        step();
        chk("rd_abort_grant", {30'd0, grant}, 32'd0);
        chk("rd_abort_busy", {31'd0, busy}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_arbiter.md
# sample_arbiter

Scheduler and sequencer for the 4-bit windowed sampler datapath. It arbitrates one shared sampling window between two requesters and runs each granted window as a blanking phase (output forced to zero) followed by a strided capture phase. It raises a per-requester completion pulse when the window ends. It sits between the requesting sources and the downstream consumer of `y`, and replaces free-running counter-gated sampling with an explicit request/grant/done handshake.

## Interface
- `W`, 4, data width of each source and of `y`
- `BLANK`, 4, blanking cycles at the start of each window (≥1)
- `CAPTURES`, 3, samples taken per window (≥1)
- `STRIDE`, 2, cycles between consecutive samples (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  global run; low freezes all state
- `req`  in  2  request per source, level, held until `done` or withdrawn
- `x0`  in  W  data of source 0
- `x1`  in  W  data of source 1
- `grant`  out  2  one-hot owner of the current window, registered
- `busy`  out  1  high whenever state ≠ IDLE
- `y`  out  W  sampled data, registered
- `y_valid`  out  1  one-cycle pulse per captured sample
- `done`  out  2  one-cycle pulse to the owner at window end

## Operation
- States: IDLE, BLANK, CAPTURE, DONE. Counters: `bcnt` (0..BLANK-1), `scnt` (0..STRIDE-1), `ncnt` (0..CAPTURES-1), pointer `last` (last served source).
- IDLE: if `req≠0`, pick a winner and set `grant` for it. Clear `y` and all counters. Go to BLANK.
- Arbitration is round-robin: a single requester wins; on a tie, the source ≠ `last` wins. `last` updates when the grant is issued.
- BLANK: `y` held at 0. After BLANK cycles, go to CAPTURE.
- CAPTURE: `scnt` counts. When `scnt==STRIDE-1`, the selected source (`x0` or `x1` per `grant`) is registered into `y`, `y_valid` pulses, and `ncnt` increments. The edge that takes sample CAPTURES moves to DONE.
- DONE: `done[owner]` is high for exactly this cycle and `grant` is still held. The next edge returns to IDLE with `grant=0`.
- Abort: if the owner's `req` drops in BLANK or CAPTURE, go to IDLE on the next edge with `grant=0`. No `done` and no further `y_valid`. `y` keeps its last value.
- `enable=0`: state, counters, `grant` and `y` hold. `y_valid` and `done` are forced to 0. Any pending pulse is emitted on the first enabled cycle.
- A non-owner request during a window is ignored until IDLE.

## Timing
- Reset values: `grant=0`, `busy=0`, `y=0`, `y_valid=0`, `done=0`, state IDLE, counters 0, `last=1` (source 0 wins the first tie).
- Reset asserted mid-window clears everything immediately (async). No `done` is produced.
- Request to grant: 1 cycle (request sampled in IDLE, `grant` visible after the next edge).
- First `y_valid`: BLANK+STRIDE cycles after `grant` rises. Subsequent samples follow every STRIDE cycles.
- Total `grant` high time is BLANK+STRIDE·CAPTURES+1 cycles. Defaults give 11.
- Back-to-back windows: after DONE, one IDLE cycle, then the next grant. The minimum gap between windows is 1 cycle with `grant=0`.
- `req` and `x*` are sampled at the rising edge. `x*` is only observed on the sample edge.

## Configuration
- `SAMPLE_ARB_PRIO_EN` defined: fixed priority; source 0 always wins ties and `last` is unused.
- `SAMPLE_ARB_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Reset release, no requests, 20 cycles: all outputs 0, `busy=0`.
- `req=01`, `x0=A` constant, defaults:
  - `grant=01` one cycle later.
  - `y=0` for 4 cycles, then `y_valid` pulses at grant+6, +8, +10 with `y=A`.
  - `done=01` at grant+10, `grant=00` at grant+11.
- `req=11` held continuously:
  - Grants alternate 01, 10, 01, … with a 1-cycle IDLE gap.
  - With `SAMPLE_ARB_PRIO_EN` defined, the grant is always 01.
- Source 1 owner, `req[1]` dropped after the first `y_valid`: state is IDLE next edge, no further `y_valid`, `done=00`, `y` holds the first sample.
- `enable=0` for 5 cycles mid-CAPTURE:
  - Nothing advances and no pulses are produced during the stall.
  - Sample timing resumes shifted by exactly 5 cycles.
- `reset` asserted asynchronously in BLANK and in DONE: outputs are 0 immediately. The next window arbitrates as after power-up, so source 0 wins a tie.
